// File: rtl/fan_vn_scheduler.sv
// Tile-command sequencer for the FAN datapath: publishes a per-PE VN map, issues
// stationary then streaming beats, and counts returned reductions to signal completion.
module fan_vn_scheduler #(
  parameter int NUM_PES  = 4,
  parameter int LOG2_PES = 2,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [LOG2_PES:0]            i_vn_size,
  input  logic [CNT_W-1:0]             i_stat_len,
  input  logic [CNT_W-1:0]             i_strm_len,
  input  logic                         i_dist_ready,
  output logic                         o_data_valid,
  output logic                         o_stationary,
  output logic [NUM_PES*LOG2_PES-1:0]  o_vn,
  input  logic                         i_reduction_valid,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int SIZE_W = LOG2_PES + 1;

  typedef enum logic [1:0] {IDLE, STAT, STRM, DRAIN} state_e;

  state_e                        state_q;
  logic                          cmdReady_q;
  logic                          dataValid_q;
  logic                          stationary_q;
  logic [NUM_PES*LOG2_PES-1:0]   vn_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          err_q;
  logic [CNT_W-1:0]              statLen_q;
  logic [CNT_W-1:0]              strmLen_q;
  logic [CNT_W-1:0]              beatCnt_q;
  logic [CNT_W-1:0]              resCnt_q;
  logic [CNT_W-1:0]              resCnt_d;

  logic                          vnLegal;
  int                            shiftAmt;
  logic [NUM_PES*LOG2_PES-1:0]   vnMap;
  logic                          beatXfer;
  logic                          lastBeat;
  logic [CNT_W-1:0]              curLen;

  // A VN size is legal only if it equals 2^k for some k in 0..LOG2_PES.
  always_comb begin
    vnLegal  = 1'b0;
    shiftAmt = 0;
    for (int k = 0; k <= LOG2_PES; k++) begin
      if (i_vn_size == SIZE_W'(1 << k)) begin
        vnLegal  = 1'b1;
        shiftAmt = k;
      end
    end
    vnMap = '0;
    for (int p = 0; p < NUM_PES; p++) begin
      vnMap[p*LOG2_PES +: LOG2_PES] = LOG2_PES'(p >> shiftAmt);
    end
  end

  // Reduction results only count once streaming has begun, and saturate at strm_len.
  always_comb begin
    resCnt_d = resCnt_q;
    if ((state_q == STRM || state_q == DRAIN) && i_reduction_valid && (resCnt_q != strmLen_q)) begin
      resCnt_d = resCnt_q + CNT_W'(1);
    end
  end

  assign beatXfer = dataValid_q & i_dist_ready;
  assign curLen   = (state_q == STAT) ? statLen_q : strmLen_q;
  assign lastBeat = (beatCnt_q + CNT_W'(1)) == curLen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmdReady_q   <= 1'b0;
      dataValid_q  <= 1'b0;
      stationary_q <= 1'b0;
      vn_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      statLen_q    <= '0;
      strmLen_q    <= '0;
      beatCnt_q    <= '0;
      resCnt_q     <= '0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      resCnt_q <= resCnt_d;
      case (state_q)
        IDLE: begin
          cmdReady_q <= 1'b1;
          if (i_cmd_valid && cmdReady_q) begin
            if (!vnLegal) begin
              err_q <= 1'b1;
            end else begin
              vn_q      <= vnMap;
              statLen_q <= i_stat_len;
              strmLen_q <= i_strm_len;
              beatCnt_q <= '0;
              resCnt_q  <= '0;
              if (i_stat_len != '0) begin
                state_q      <= STAT;
                cmdReady_q   <= 1'b0;
                busy_q       <= 1'b1;
                dataValid_q  <= 1'b1;
                stationary_q <= 1'b1;
              end else if (i_strm_len != '0) begin
                state_q      <= STRM;
                cmdReady_q   <= 1'b0;
                busy_q       <= 1'b1;
                dataValid_q  <= 1'b1;
                stationary_q <= 1'b0;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
        end
        STAT: begin
          if (beatXfer) begin
            beatCnt_q <= beatCnt_q + CNT_W'(1);
            if (lastBeat) begin
              beatCnt_q    <= '0;
              stationary_q <= 1'b0;
              if (strmLen_q != '0) begin
                state_q <= STRM;
              end else begin
                state_q     <= IDLE;
                dataValid_q <= 1'b0;
                busy_q      <= 1'b0;
                cmdReady_q  <= 1'b1;
                done_q      <= 1'b1;
              end
            end
          end
        end
        STRM: begin
          if (beatXfer) begin
            beatCnt_q <= beatCnt_q + CNT_W'(1);
            if (lastBeat) begin
              beatCnt_q   <= '0;
              dataValid_q <= 1'b0;
              state_q     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Compare the post-increment count so a pulse seen here finishes next cycle.
          if (resCnt_d == strmLen_q) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cmdReady_q <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = cmdReady_q;
  assign o_data_valid = dataValid_q;
  assign o_stationary = stationary_q;
  assign o_vn         = vn_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_fan_vn_scheduler.sv
// Self-checking bench for fan_vn_scheduler: per-scenario cycle tables plus a beat
// scoreboard that pops the expected beat type on every valid/ready transfer.
module tb_fan_vn_scheduler;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_vn_size;
  logic [15:0] i_stat_len;
  logic [15:0] i_strm_len;
  logic        i_dist_ready;
  logic        o_data_valid;
  logic        o_stationary;
  logic [7:0]  o_vn;
  logic        i_reduction_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int checks = 0;
  int errors = 0;
  logic expBeats[$];

  // Status vector: {cmd_ready, busy, data_valid, stationary, done, err}
  logic [5:0] st;
  assign st = {o_cmd_ready, o_busy, o_data_valid, o_stationary, o_done, o_err};

  fan_vn_scheduler #(.NUM_PES(4), .LOG2_PES(2), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_vn_size(i_vn_size),
    .i_stat_len(i_stat_len),
    .i_strm_len(i_strm_len),
    .i_dist_ready(i_dist_ready),
    .o_data_valid(o_data_valid),
    .o_stationary(o_stationary),
    .o_vn(o_vn),
    .i_reduction_valid(i_reduction_valid),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every accepted beat must match the head of the expected beat queue.
  always @(negedge clk) begin
    if (!rst && o_data_valid && i_dist_ready) begin
      checks++;
      if (expBeats.size() == 0) begin
        errors++;
        $display("[TB] FAIL beat_unexpected: got beat stationary=%0b, required no beat", o_stationary);
      end else begin
        logic expStat;
        expStat = expBeats.pop_front();
        if (o_stationary !== expStat) begin
          errors++;
          $display("[TB] FAIL beat_type: got stationary=%0b, required %0b", o_stationary, expStat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendCmd(input logic [2:0] vs, input logic [15:0] sl, input logic [15:0] ml);
    i_cmd_valid = 1'b1;
    i_vn_size   = vs;
    i_stat_len  = sl;
    i_strm_len  = ml;
    if (vs == 3'd1 || vs == 3'd2 || vs == 3'd4) begin
      repeat (sl) expBeats.push_back(1'b1);
      repeat (ml) expBeats.push_back(1'b0);
    end
    tick();
    i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (st !== 6'b000000 || o_vn !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_values: got st=%b vn=%h, required st=000000 vn=00", st, o_vn);
    end
    rst = 1'b0;
    checks++;
    if (o_cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready_early: got %b, required 0", o_cmd_ready);
    end
    tick();
    checks++;
    if (st !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL reset_ready_rise: got st=%b, required 100000", st);
    end
  endtask

  task automatic test_normal();
    logic [5:0] expSt [11];
    logic [15:0] redMask;
    expSt = '{6'b011100, 6'b011100, 6'b011000, 6'b011000, 6'b011000, 6'b010000,
              6'b010000, 6'b010000, 6'b010000, 6'b100010, 6'b100000};
    redMask = 16'h0380;
    i_dist_ready = 1'b1;
    sendCmd(3'd2, 16'd2, 16'd3);
    checks++;
    if (o_vn !== 8'h50) begin
      errors++;
      $display("[TB] FAIL normal_vn: got %h, required 50", o_vn);
    end
    for (int c = 1; c <= 11; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL normal_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      if (c == 10) begin
        checks++;
        if (expBeats.size() != 0) begin
          errors++;
          $display("[TB] FAIL normal_beats_left: got %0d, required 0", expBeats.size());
        end
      end
      i_reduction_valid = redMask[c];
      tick();
    end
    i_reduction_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [5:0] expSt [15];
    logic [15:0] redMask;
    logic [15:0] rdyMask;
    expSt = '{6'b011100, 6'b011100, 6'b011100, 6'b011000, 6'b011000, 6'b011000,
              6'b011000, 6'b011000, 6'b011000, 6'b010000, 6'b010000, 6'b010000,
              6'b010000, 6'b100010, 6'b100000};
    redMask = 16'h3804;
    rdyMask = 16'hAAAA;
    sendCmd(3'd2, 16'd2, 16'd3);
    for (int c = 1; c <= 15; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL backpressure_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      if (c == 14) begin
        checks++;
        if (expBeats.size() != 0) begin
          errors++;
          $display("[TB] FAIL backpressure_beats_left: got %0d, required 0", expBeats.size());
        end
      end
      i_reduction_valid = redMask[c];
      i_dist_ready      = rdyMask[c];
      tick();
    end
    i_reduction_valid = 1'b0;
    i_dist_ready      = 1'b1;
  endtask

  task automatic test_zero_len();
    logic [5:0] expSt [4];
    sendCmd(3'd4, 16'd0, 16'd0);
    checks++;
    if (st !== 6'b100010 || o_vn !== 8'h00) begin
      errors++;
      $display("[TB] FAIL zero_both_done: got st=%b vn=%h, required 100010 vn=00", st, o_vn);
    end
    tick();
    checks++;
    if (st !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL zero_both_after: got st=%b, required 100000", st);
    end
    expSt = '{6'b011000, 6'b010000, 6'b100010, 6'b100000};
    sendCmd(3'd1, 16'd0, 16'd1);
    checks++;
    if (o_vn !== 8'hE4) begin
      errors++;
      $display("[TB] FAIL zero_stat_vn: got %h, required e4", o_vn);
    end
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL zero_stat_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      i_reduction_valid = (c == 1);
      tick();
    end
    i_reduction_valid = 1'b0;
  endtask

  task automatic test_illegal();
    logic [2:0] badSizes [4];
    badSizes = '{3'd3, 3'd0, 3'd5, 3'd6};
    for (int i = 0; i < 4; i++) begin
      sendCmd(badSizes[i], 16'd2, 16'd2);
      checks++;
      if (st !== 6'b100001 || o_vn !== 8'hE4) begin
        errors++;
        $display("[TB] FAIL illegal_%0d_err: got st=%b vn=%h, required 100001 vn=e4", badSizes[i], st, o_vn);
      end
      tick();
      checks++;
      if (st !== 6'b100000) begin
        errors++;
        $display("[TB] FAIL illegal_%0d_after: got st=%b, required 100000", badSizes[i], st);
      end
    end
  endtask

  task automatic test_drain_extra();
    logic [5:0] expSt [8];
    logic [15:0] redMask;
    expSt = '{6'b011100, 6'b011000, 6'b011000, 6'b010000,
              6'b010000, 6'b100010, 6'b100000, 6'b100000};
    redMask = 16'h00F0;
    sendCmd(3'd4, 16'd1, 16'd2);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL drain_extra_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      i_reduction_valid = redMask[c];
      tick();
    end
    i_reduction_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] expSt [3];
    expSt = '{6'b011000, 6'b010000, 6'b100010};
    sendCmd(3'd2, 16'd0, 16'd1);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL b2b_a_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      i_reduction_valid = (c == 1);
      if (c < 3) tick();
    end
    i_reduction_valid = 1'b0;
    sendCmd(3'd1, 16'd1, 16'd0);
    checks++;
    if (st !== 6'b011100 || o_vn !== 8'hE4) begin
      errors++;
      $display("[TB] FAIL b2b_b_start: got st=%b vn=%h, required 011100 vn=e4", st, o_vn);
    end
    tick();
    checks++;
    if (st !== 6'b100010) begin
      errors++;
      $display("[TB] FAIL b2b_b_done: got st=%b, required 100010", st);
    end
    tick();
    checks++;
    if (st !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL b2b_b_after: got st=%b, required 100000", st);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] expSt [5];
    sendCmd(3'd2, 16'd0, 16'd3);
    checks++;
    if (st !== 6'b011000) begin
      errors++;
      $display("[TB] FAIL rstmid_c1: got st=%b, required 011000", st);
    end
    i_reduction_valid = 1'b1;
    tick();
    checks++;
    if (st !== 6'b011000) begin
      errors++;
      $display("[TB] FAIL rstmid_c2: got st=%b, required 011000", st);
    end
    i_reduction_valid = 1'b0;
    i_dist_ready      = 1'b0;
    rst               = 1'b1;
    expBeats.delete();
    tick();
    checks++;
    if (st !== 6'b000000 || o_vn !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rstmid_cleared: got st=%b vn=%h, required 000000 vn=00", st, o_vn);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (st !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL rstmid_ready: got st=%b, required 100000", st);
    end
    i_dist_ready = 1'b1;
    expSt = '{6'b011100, 6'b011000, 6'b010000, 6'b100010, 6'b100000};
    sendCmd(3'd4, 16'd1, 16'd1);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (st !== expSt[c-1]) begin
        errors++;
        $display("[TB] FAIL rstmid_new_c%0d: got st=%b, required %b", c, st, expSt[c-1]);
      end
      i_reduction_valid = (c == 2);
      tick();
    end
    i_reduction_valid = 1'b0;
    checks++;
    if (expBeats.size() != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_beats_left: got %0d, required 0", expBeats.size());
    end
  endtask

  initial begin
    rst               = 1'b1;
    i_cmd_valid       = 1'b0;
    i_vn_size         = 3'd0;
    i_stat_len        = 16'd0;
    i_strm_len        = 16'd0;
    i_dist_ready      = 1'b1;
    i_reduction_valid = 1'b0;
    test_reset();
    test_normal();
    test_backpressure();
    test_zero_len();
    test_illegal();
    test_drain_extra();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_vn_scheduler.md
# fan_vn_scheduler

Command-driven sequencer that sits in front of the FAN reduction controller and the distribution network. It converts a tile command into three things: a stable per-PE virtual-neuron (VN) map, a stationary-load phase, and a streaming phase, each with valid/ready beat flow. It then counts the reduction-valid pulses returned from the FAN and reports command completion.

## Interface
- NUM_PES, 4: number of PEs/multipliers; must be a power of two, ≥2.
- LOG2_PES, 2: log2(NUM_PES); width of one VN id.
- CNT_W, 16: width of the beat-length fields and internal counters.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  scheduler can accept a command
- i_vn_size  in  LOG2_PES+1  PEs per VN; legal values are 1,2,4..NUM_PES
- i_stat_len  in  CNT_W  stationary beats to issue
- i_strm_len  in  CNT_W  streaming beats to issue (equals expected reduction results)
- i_dist_ready  in  1  distribution network accepts the current beat
- o_data_valid  out  1  beat valid to distribution network and FAN ctrl
- o_stationary  out  1  current beat is stationary (1) or streaming (0)
- o_vn  out  NUM_PES*LOG2_PES  VN id per PE; PE p occupies bits [p*LOG2_PES +: LOG2_PES]
- i_reduction_valid  in  1  one reduction result emitted by the FAN
- o_busy  out  1  command in progress (state ≠ IDLE)
- o_done  out  1  one-cycle pulse when a command completes
- o_err  out  1  one-cycle pulse when an illegal command is rejected

## Operation
- FSM states: IDLE, STAT, STRM, DRAIN. All outputs are registered.
- **IDLE**
  - o_cmd_ready=1.
  - On i_cmd_valid&o_cmd_ready, latch the lengths and compute o_vn[p] = p >> log2(i_vn_size).
  - Illegal i_vn_size (0, >NUM_PES, or not a power of two): consume the command, pulse o_err next cycle, stay IDLE, leave o_vn unchanged.
- **Next-state on legal accept:**
  - stat_len≠0 → STAT.
  - stat_len=0, strm_len≠0 → STRM.
  - Both zero → pulse o_done next cycle, stay IDLE.
- **STAT:** o_data_valid=1, o_stationary=1. A beat transfers when o_data_valid&i_dist_ready. After beat stat_len transfers, go to STRM (or to IDLE with o_done if strm_len=0).
- **STRM:** o_data_valid=1, o_stationary=0. After beat strm_len transfers, go to DRAIN.
- **DRAIN:** o_data_valid=0. Wait until the result counter equals strm_len, then pulse o_done and return to IDLE.
- **Result counter**
  - Cleared on accept.
  - Increments on i_reduction_valid only in STRM or DRAIN.
  - Saturates at strm_len.
  - Pulses in IDLE or STAT are ignored.
- **o_vn** is held constant from the cycle after accept until the next legal accept. This covers the FAN ctrl's internal VN delay pipeline.
- o_cmd_ready=0 in every state except IDLE; no command queuing.

## Timing
- Reset values: o_cmd_ready=0, o_data_valid=0, o_stationary=0, o_vn=0, o_busy=0, o_done=0, o_err=0, state IDLE, counters 0. o_cmd_ready rises the first cycle after rst deasserts.
- Accept at cycle T → o_busy=1 and first beat valid at T+1.
- No bubble between phases: the last STAT transfer at cycle k is followed by o_stationary=0, o_data_valid=1 at k+1.
- While i_dist_ready=0, o_data_valid and o_stationary hold their values.
- The last STRM transfer at cycle m drives o_data_valid=0 at m+1.
- o_done pulses one cycle after the cycle in which the counter reaches strm_len while in DRAIN. If the final i_reduction_valid arrives in the same cycle as the last STRM transfer, o_done pulses at m+2 (one DRAIN cycle).
- o_cmd_ready=1 in the same cycle as o_done, so back-to-back commands are possible.
- rst mid-command returns all outputs to reset values on the next edge, regardless of state. Counts are lost and no o_done is issued.

## Test plan
- **Normal command, dist_ready=1 always:** NUM_PES=4, vn_size=2, stat_len=2, strm_len=3 → o_vn=8'b01_01_00_00. Two stationary beats at T+1..T+2, three streaming beats at T+3..T+5. Three reduction pulses at T+7..T+9 give o_done at T+10.
- **Backpressure:** same command with i_dist_ready toggling 1,0,1,0… → exactly 2 stationary and 3 streaming transfers. o_data_valid/o_stationary are held during stalls.
- **Zero-length cases:**
  - stat_len=0, strm_len=1 → goes straight to STRM.
  - stat_len=0, strm_len=0 → o_done at T+1, no beats.
- **Illegal vn_size=3** → o_err at T+1, o_busy stays 0, o_vn unchanged from the prior command.
- **Reduction-count corner cases:**
  - A spurious i_reduction_valid during STAT is ignored.
  - The final reduction pulse coincides with the last STRM beat → o_done two cycles after that beat.
  - Extra pulses in DRAIN do not cause a double o_done.
- **Reset during STRM after 1 of 3 beats** → all outputs 0 next cycle, o_cmd_ready=1 one cycle after rst deasserts, and a new command runs cleanly.
